bitfusion_column_collector: RTL and testbench

Output-side reader for a BitFusion column. Tracks every input vector launched into the column through a latency-matched token pipeline, samples the column accumulator's 28-bit `total_output` when a tile-final token emerges, and requantises the result with an arithmetic shift and saturation. Results are queued in a small FIFO and presented on a valid/ready stream toward the output buffer. It sits between the column's `ACC` output and the output SRAM writer, one instance per column.

---
 rtl/bitfusion_column_collector.sv | 158 +++++++++++++++
 tb/tb_bitfusion_column_collector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitfusion_column_collector.sv
`default_nettype none
// ============================================================================
// Module   : bitfusion_column_collector
// Brief    : Column output reader. Latency-matched token tracking, capture,
//            requantisation and a show-ahead result FIFO on a valid/ready port.
// Revision : 1.0
// ============================================================================
module bitfusion_column_collector #(
   parameter int LATENCY    = 20,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          issue,
   input  logic                          issue_last,
   input  logic [27:0]                   total_output,
   input  logic [4:0]                    out_shift,
   output logic [15:0]                   out_data,
   output logic                          out_sat,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          clear_ovf,
   output logic                          busy,
   output logic [1:0]                    fsm_state
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_INF_W = $clog2(LATENCY + 1);
   localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   logic [LATENCY-1:0]   r_tok_valid;
   logic [LATENCY-1:0]   r_tok_last;
   logic [c_INF_W-1:0]   r_inflight;
   logic [16:0]          r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W:0]     r_count;
   logic                 r_overflow;
   state_t               r_state;

   logic                 w_emerge;
   logic                 w_capture;
   logic signed [27:0]   w_shifted;
   logic                 w_hi;
   logic                 w_lo;
   logic [15:0]          w_req_data;
   logic                 w_req_sat;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;

   assign w_emerge  = r_tok_valid[LATENCY-1];
   assign w_capture = w_emerge & r_tok_last[LATENCY-1];

   assign w_shifted  = $signed(total_output) >>> out_shift;
   assign w_hi       = w_shifted > 28'sd32767;
   assign w_lo       = w_shifted < -28'sd32768;
   assign w_req_data = w_hi ? 16'h7FFF : (w_lo ? 16'h8000 : w_shifted[15:0]);
   assign w_req_sat  = w_hi | w_lo;

   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign w_full = (r_count == c_FULL);
   assign w_pop  = out_valid & out_ready;
   assign w_push = w_capture & (~w_full | w_pop);
   assign w_drop = w_capture & w_full & ~w_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tok_valid <= '0;
         r_tok_last  <= '0;
         r_inflight  <= '0;
      end else begin
         r_tok_valid[0] <= issue;
         r_tok_last[0]  <= issue & issue_last;
         for (int i = 1; i < LATENCY; i++) begin
            r_tok_valid[i] <= r_tok_valid[i-1];
            r_tok_last[i]  <= r_tok_last[i-1];
         end
         case ({issue, w_emerge})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Storage is not reset; the head is masked by out_valid instead.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {w_req_sat, w_req_data};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clear_ovf)
            r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (issue)
                  r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (!issue && r_inflight == '0)
                  r_state <= (r_count != '0) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
               if (issue)
                  r_state <= ST_RUN;
               else if (r_count == '0)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid  = (r_count != '0);
   assign out_data   = out_valid ? r_mem[r_rd_ptr][15:0] : 16'h0000;
   assign out_sat    = out_valid & r_mem[r_rd_ptr][16];
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
   assign busy       = (r_state != ST_IDLE);
   assign fsm_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bitfusion_column_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitfusion_column_collector
// Brief    : Randomised and directed bench against a time-scheduled token /
//            result-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_bitfusion_column_collector;

   localparam int LAT   = 20;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        issue = 1'b0;
   logic        issue_last = 1'b0;
   logic [27:0] total_output = '0;
   logic [4:0]  out_shift = '0;
   logic        out_ready = 1'b0;
   logic        clear_ovf = 1'b0;
   logic [15:0] out_data;
   logic        out_sat;
   logic        out_valid;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic        busy;
   logic [1:0]  fsm_state;

   bitfusion_column_collector #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .issue(issue), .issue_last(issue_last),
      .total_output(total_output), .out_shift(out_shift),
      .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
      .out_ready(out_ready), .fifo_count(fifo_count), .overflow(overflow),
      .clear_ovf(clear_ovf), .busy(busy), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: tokens are scheduled by the edge at which they emerge.
   typedef struct { int due; bit last; } tok_t;
   typedef struct { logic [15:0] d; bit s; } ent_t;
   tok_t tq[$];
   ent_t fq[$];
   bit   m_ovf = 0;
   int   m_state = 0;
   int   cyc = 0;

   function automatic ent_t requant(logic [27:0] t, logic [4:0] sh);
      longint v;
      ent_t   e;
      v = {{36{t[27]}}, t};
      v = v >>> sh;
      if (v > 32767)       begin e.d = 16'h7FFF; e.s = 1; end
      else if (v < -32768) begin e.d = 16'h8000; e.s = 1; end
      else                 begin e.d = v[15:0];  e.s = 0; end
      return e;
   endfunction

   task automatic model_reset();
      tq.delete();
      fq.delete();
      m_ovf   = 0;
      m_state = 0;
   endtask

   task automatic model_edge();
      int inf0, f0;
      bit pop, cap, drop;
      cyc++;
      if (!reset) begin
         model_reset();
         return;
      end
      inf0 = tq.size();
      f0   = fq.size();
      case (m_state)
         0: if (issue) m_state = 1;
         1: if (!issue && inf0 == 0) m_state = (f0 != 0) ? 2 : 0;
         2: if (issue) m_state = 1; else if (f0 == 0) m_state = 0;
         default: m_state = 0;
      endcase
      pop  = (f0 != 0) && out_ready;
      cap  = 0;
      drop = 0;
      if (tq.size() > 0 && tq[0].due == cyc) begin
         cap = tq[0].last;
         void'(tq.pop_front());
      end
      if (pop) void'(fq.pop_front());
      if (cap) begin
         if (f0 < DEPTH || pop) fq.push_back(requant(total_output, out_shift));
         else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
      if (issue) tq.push_back('{due: cyc + LAT, last: issue_last});
   endtask

   task automatic check_outputs();
      check("out_valid", out_valid, fq.size() != 0);
      check("fifo_count", fifo_count, fq.size());
      check("overflow", overflow, m_ovf);
      check("busy", busy, m_state != 0);
      check("fsm_state", fsm_state, m_state);
      if (fq.size() != 0) begin
         check("out_data", out_data, fq[0].d);
         check("out_sat", out_sat, fq[0].s);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic drive(bit iss, bit lst, logic [27:0] tot, bit rdy, bit clr);
      issue = iss; issue_last = lst; total_output = tot;
      out_ready = rdy; clear_ovf = clr;
      tick();
   endtask

   task automatic idle(int n, bit rdy);
      repeat (n) drive(0, 0, total_output, rdy, 0);
   endtask

   logic [27:0] sat_in  [3] = '{28'h7FFFFFF, 28'h8000000, 28'hFFFFFE0};
   logic [15:0] sat_exp [3] = '{16'h7FFF, 16'h8000, 16'hFFFE};
   bit          sat_flg [3] = '{1'b1, 1'b1, 1'b0};

   initial begin
      repeat (2) tick();
      check("rst_data", out_data, 0);
      check("rst_sat", out_sat, 0);
      check("rst_valid", out_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_busy", busy, 0);
      check("rst_state", fsm_state, 0);
      reset = 1'b1;

      // Single tile
      out_shift = 5'd0;
      idle(3, 0);
      drive(1, 1, 28'h0000123, 0, 0);
      idle(LAT - 1, 0);
      check("single_early", out_valid, 0);
      idle(1, 0);
      check("single_valid", out_valid, 1);
      check("single_data", out_data, 16'h0123);
      check("single_sat", out_sat, 0);
      idle(4, 1);
      check("single_idle", fsm_state, 2'b00);

      // Saturation
      out_shift = 5'd4;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, sat_in[i], 0, 0);
         idle(LAT, 0);
         check("sat_data", out_data, sat_exp[i]);
         check("sat_flag", out_sat, sat_flg[i]);
         idle(4, 1);
      end

      // Mixed tokens
      out_shift = 5'd0;
      for (int i = 0; i < 10; i++) drive(1, (i % 5) == 4, $urandom, 0, 0);
      idle(LAT + 2, 0);
      check("mixed_count", fifo_count, 2);
      idle(6, 1);

      // Backpressure with drop, then clear
      for (int i = 0; i < 9; i++) drive(1, 1, $urandom, 0, 0);
      idle(LAT, 0);
      check("bp_full", fifo_count, 8);
      check("bp_ovf", overflow, 1);
      drive(0, 0, total_output, 0, 1);
      check("ovf_clear", overflow, 0);
      idle(12, 1);

      // Backpressure with a pop on the 9th capture
      for (int i = 0; i < 9; i++) drive(1, 1, $urandom, 0, 0);
      idle(LAT - 1, 0);
      drive(0, 0, total_output, 1, 0);
      check("bp_pop_count", fifo_count, 8);
      check("bp_pop_ovf", overflow, 0);
      idle(12, 1);

      // Clear coincident with a dropped push
      for (int i = 0; i < 9; i++) drive(1, 1, $urandom, 0, 0);
      idle(LAT - 1, 0);
      drive(0, 0, total_output, 0, 1);
      check("ovf_set_wins", overflow, 1);
      drive(0, 0, total_output, 0, 1);
      check("ovf_clear2", overflow, 0);
      idle(12, 1);

      // Randomised phases; shift changes only while idle
      for (int p = 0; p < 4; p++) begin
         out_shift = 5'($urandom_range(0, 16));
         repeat (300)
            drive(($urandom % 3) == 0, $urandom % 2, 28'($urandom),
                  ($urandom % 4) != 0, ($urandom % 50) == 0);
         idle(LAT + 12, 1);
      end

      // Mid-tile asynchronous reset
      out_shift = 5'd2;
      drive(1, 1, 28'h0001000, 0, 0);
      drive(1, 1, 28'h0001000, 0, 0);
      idle(LAT, 0);
      check("mid_queued", fifo_count, 2);
      drive(1, 1, 28'h0002000, 0, 0);
      idle(2, 0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("mid_rst_data", out_data, 0);
      check("mid_rst_sat", out_sat, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_state", fsm_state, 0);
      repeat (3) tick();
      reset = 1'b1;
      idle(LAT + 10, 1);
      check("post_rst_none", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
